// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial bit-pattern detector with Mealy match output,
// selectable overlap mode, registered match copy and saturating hit counter.
module seq_detector_prog #(
    parameter int              PAT_W   = 8,
    parameter int              CNT_W   = 16,
    parameter logic [PAT_W-1:0] DEF_PAT = 8'b10110,
    parameter int              DEF_LEN = 5,
    parameter logic            DEF_OVL = 1'b0,
    localparam int             LEN_W   = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    output logic             cfg_err,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             match,
    output logic             match_q,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] match_cnt
);

    typedef enum logic {StHunt, StArmed} state_t;

    localparam logic [LEN_W-1:0] DefLen   = LEN_W'(DEF_LEN);
    localparam state_t           DefState = (DEF_LEN == 1) ? StArmed : StHunt;
    localparam logic [CNT_W-1:0] CntMax   = '1;

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [PAT_W-2:0]   hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               cfg_err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept;
    logic               cfg_ok;
    logic [LEN_W-1:0]   len_m1;
    logic [PAT_W-1:0]   window;
    logic [PAT_W-1:0]   mask;
    logic               hit;

    assign accept = in_valid & ~cfg_load;
    assign cfg_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
    assign len_m1 = len_q - LEN_W'(1);
    assign window = {hist_q, in_bit};

    // Only the low len_q bits of the window take part in the comparison.
    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
    end

    assign hit   = ((window ^ pat_q) & mask) == '0;
    assign match = (state_q == StArmed) & accept & hit;

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        cfg_err_d = 1'b0;

        if (cfg_load) begin
            if (cfg_ok) begin
                pat_d   = cfg_pattern;
                len_d   = cfg_len;
                ovl_d   = cfg_overlap;
                hist_d  = '0;
                fill_d  = '0;
                state_d = (cfg_len == LEN_W'(1)) ? StArmed : StHunt;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (in_valid) begin
            hist_d = window[PAT_W-2:0];
            case (state_q)
                StHunt: begin
                    fill_d  = fill_q + LEN_W'(1);
                    state_d = (fill_q + LEN_W'(1) == len_m1) ? StArmed : StHunt;
                end
                StArmed: begin
                    // Non-overlap restart: a fresh len_q bits are needed before the next hit.
                    if (match && !ovl_q) begin
                        fill_d  = '0;
                        state_d = (len_q == LEN_W'(1)) ? StArmed : StHunt;
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (match && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DefState;
            pat_q   <= DEF_PAT;
            len_q   <= DefLen;
            ovl_q   <= DEF_OVL;
            hist_q  <= '0;
            fill_q  <= '0;
            cfg_err <= 1'b0;
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cfg_err <= cfg_err_d;
            match_q <= match;
            cnt_q   <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;

endmodule
